frankie_mem_responder: RTL and testbench
========================================

Name: frankie_mem_responder

Overview:
- Memory-side responder for the Frankie multicycle CPU's data/instruction memory port. It answers one outstanding read or write request at a time.
- Handshakes are valid/ready on both the request and response channels.
- A fixed, parameterised access latency models slow memory, so the CPU control FSM can be exercised against real wait states.
- Holds a word-addressed 16-bit RAM array and returns an error flag for out-of-range addresses.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 10, request address width (word address).
- DEPTH, 1024, number of implemented words; must be ≤ 2^ADDR_W.
- LATENCY, 2, extra wait cycles between accepting a request and committing the access; 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU consumes the response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address ≥ DEPTH.
- resp_count  out  16  number of completed responses; wraps.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset = 0:
  - state = IDLE.
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, resp_count = 0.
  - Latched request fields are cleared.
  - The RAM array is NOT cleared; its contents persist across reset.
- The first edge after reset deasserts puts the block in IDLE with req_ready = 1.

State machine (IDLE, WAIT, RESP):
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1, latch req_write, req_addr and req_wdata, load cnt = LATENCY, and go to WAIT.
- WAIT:
  - req_ready = 0, resp_valid = 0.
  - If cnt ≠ 0, decrement cnt on each edge.
  - If cnt = 0, the next edge commits the access and moves to RESP:
    - Read, in range: resp_rdata ← mem[addr], resp_err ← 0.
    - Write, in range: mem[addr] ← wdata, resp_rdata ← 0, resp_err ← 0.
    - Out of range (addr ≥ DEPTH): no array access, resp_rdata ← 0, resp_err ← 1.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable.
  - On an edge with resp_ready = 1: go to IDLE, clear resp_valid, resp_rdata and resp_err, and increment resp_count (modulo 2^16).
  - With resp_ready = 0, RESP is held indefinitely.

Timing and throughput:
- Accept edge N → commit edge N+LATENCY+1 → resp_valid high in the cycle after that edge.
- If resp_ready is already high, the handshake is on edge N+LATENCY+2.
- A new request cannot be accepted on the response-handshake edge. req_ready rises the cycle after, so minimum spacing between accepts is LATENCY+3 edges.

Input stability:
- Request inputs are sampled only on the accept edge. Changes afterwards are ignored.
- req_valid held high through WAIT/RESP does not create a second accept.

Reset mid-operation:
- A request still in WAIT is dropped, and a pending write is not committed.
- A write already committed remains in memory.
- A pending response is discarded, and resp_count is cleared.

Boundaries:
- resp_count wraps 0xFFFF → 0x0000.
- Address DEPTH-1 is valid; DEPTH is an error.

Test Plan:
- Reset/idle: hold reset = 0 for 3 cycles with req_valid = 1 → req_ready = 0, resp_valid = 0, resp_count = 0. After release, req_ready = 1 on the next edge.
- Write then read, LATENCY = 2:
  - Write addr 5, data 0x0007, resp_ready = 1 → resp_valid pulses 1 cycle after the commit edge (accept+3), with rdata = 0 and err = 0.
  - Read addr 5 → rdata = 0x0007; resp_count = 2.
- Backpressure: read addr 5 with resp_ready = 0 for 6 cycles → resp_valid and rdata = 0x0007 held constant. Raise resp_ready → one handshake, IDLE, and req_ready = 1 on the next cycle.
- Out of range, DEPTH = 1000:
  - Write addr 1000, data 0x1234 → err = 1.
  - Read addr 999 returns its prior value; read addr 1000 → rdata = 0, err = 1.
- Reset mid-write: write addr 3, data 0x00AA (prior value 0x0011), and assert reset during WAIT → after release, read addr 3 = 0x0011.
- Latency sweep and wrap:
  - Benches with LATENCY = 0 and 15 measure accept-to-resp_valid delay as LATENCY+1 cycles after the accept edge.
  - Force resp_count to 0xFFFF via 65535 transactions (or a hierarchical preload), then one more → 0x0000.

Source files
------------

// File: rtl/frankie_mem_responder.sv
// frankie_mem_responder
//   Memory-side responder for the Frankie multicycle CPU. It serves one
//   outstanding read or write at a time. A fixed wait of LATENCY cycles between
//   accepting a request and committing it models slow memory.
//
// State table
//   state | meaning
//   IDLE  | ready to accept a request (req_ready = 1 once out of reset)
//   WAIT  | request latched, counting down the access latency
//   RESP  | access committed, response presented until resp_ready
//
// Ports
//   clock       in   rising-edge system clock
//   reset       in   asynchronous, active-low reset
//   req_valid   in   CPU presents a request
//   req_ready   out  responder can accept a request
//   req_write   in   1 = write, 0 = read
//   req_addr    in   word address
//   req_wdata   in   write data
//   resp_valid  out  response available
//   resp_ready  in   CPU consumes the response
//   resp_rdata  out  read data (0 for writes and errors)
//   resp_err    out  address was >= DEPTH
//   resp_count  out  completed responses, wraps at 2^16
module frankie_mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [15:0]       resp_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_L   = 4'(LATENCY);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                lat_write_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                commit;
  logic                handshake;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

  always_comb begin
    // req_ready gates accept so the first edge after reset cannot take a request.
    accept    = (state_q == ST_IDLE) && req_ready && req_valid;
    commit    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    handshake = (state_q == ST_RESP) && resp_ready;
    in_range  = {1'b0, lat_addr_q} < DEPTH_L;
    idx       = lat_addr_q[IDX_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_WAIT;
      ST_WAIT: if (commit)    state_d = ST_RESP;
      ST_RESP: if (handshake) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  assign resp_valid = (state_q == ST_RESP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_ready   <= 1'b0;
      cnt_q       <= 4'd0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      resp_count  <= 16'd0;
    end else begin
      state_q   <= state_d;
      // Registered so ready rises one cycle after the response handshake.
      req_ready <= (state_d == ST_IDLE);

      if (accept) begin
        lat_write_q <= req_write;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        cnt_q       <= LAT_L;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (commit) begin
        resp_err   <= !in_range;
        resp_rdata <= (!lat_write_q && in_range) ? mem[idx] : '0;
      end else if (handshake) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
        resp_count <= resp_count + 16'd1;
      end
    end
  end

  // The array has no reset so its contents persist across reset.
  always_ff @(posedge clock) begin
    if (commit && lat_write_q && in_range)
      mem[idx] <= lat_wdata_q;
  end

endmodule

// File: tb/tb_frankie_mem_responder.sv
module tb_frankie_mem_responder;

  localparam int N = 3;   // 0: LATENCY 0, 1: LATENCY 2 / DEPTH 1000, 2: LATENCY 15

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rv   [N];
  logic        rw   [N];
  logic        rrd  [N];
  logic        rdy  [N];
  logic        vld  [N];
  logic        err  [N];
  logic [9:0]  ra   [N];
  logic [15:0] wd   [N];
  logic [15:0] rdat [N];
  logic [15:0] rcnt [N];

  int npass = 0;
  int ntot  = 0;

  frankie_mem_responder #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .LATENCY(0)) u_l0 (
    .clock(clk), .reset(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(wd[0]), .resp_valid(vld[0]), .resp_ready(rrd[0]),
    .resp_rdata(rdat[0]), .resp_err(err[0]), .resp_count(rcnt[0]));

  frankie_mem_responder #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .LATENCY(2)) u_l2 (
    .clock(clk), .reset(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(wd[1]), .resp_valid(vld[1]), .resp_ready(rrd[1]),
    .resp_rdata(rdat[1]), .resp_err(err[1]), .resp_count(rcnt[1]));

  frankie_mem_responder #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .LATENCY(15)) u_l15 (
    .clock(clk), .reset(rst_n), .req_valid(rv[2]), .req_ready(rdy[2]), .req_write(rw[2]),
    .req_addr(ra[2]), .req_wdata(wd[2]), .resp_valid(vld[2]), .resp_ready(rrd[2]),
    .resp_rdata(rdat[2]), .resp_err(err[2]), .resp_count(rcnt[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after its accept edge.
  task automatic send(input int i, input logic w, input logic [9:0] a, input logic [15:0] d);
    int n = 0;
    while (!rdy[i] && n < 40) begin
      step();
      n++;
    end
    chk("req_ready_before_send", {31'd0, rdy[i]}, 32'd1);
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; wd[i] = d;
    step();
    rv[i] = 1'b0;
  endtask

  // Edges from the accept edge until resp_valid is seen high.
  task automatic wait_resp(input int i, output int k);
    k = 0;
    while (!vld[i] && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) chk("resp_valid_timeout", {31'd0, vld[i]}, 32'd1);
  endtask

  // Full transaction with resp_ready assumed high.
  task automatic xact(input int i, input logic w, input logic [9:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic e, output int k);
    send(i, w, a, d);
    wait_resp(i, k);
    rd = rdat[i];
    e  = err[i];
    step();
  endtask

  logic [15:0] rd;
  logic        e;
  int          k;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b1; rw[i] = 1'b0; ra[i] = '0; wd[i] = '0; rrd[i] = 1'b1;
    end
    repeat (3) step();
    chk("rst_req_ready",  {31'd0, rdy[1]}, 32'd0);
    chk("rst_resp_valid", {31'd0, vld[1]}, 32'd0);
    chk("rst_resp_count", {16'd0, rcnt[1]}, 32'd0);
    chk("rst_resp_rdata", {16'd0, rdat[1]}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    step();
    chk("post_rst_ready_l2",  {31'd0, rdy[1]}, 32'd1);
    chk("post_rst_ready_l15", {31'd0, rdy[2]}, 32'd1);

    // Write addr 5 with LATENCY 2
    send(1, 1'b1, 10'd5, 16'h0007);
    chk("wait_ready_low", {31'd0, rdy[1]}, 32'd0);
    wait_resp(1, k);
    chk("lat2_write_delay", k, 32'd3);
    chk("write_rdata", {16'd0, rdat[1]}, 32'd0);
    chk("write_err",   {31'd0, err[1]}, 32'd0);
    step();
    chk("pulse_valid_low",   {31'd0, vld[1]}, 32'd0);
    chk("ready_after_hs",    {31'd0, rdy[1]}, 32'd1);
    chk("count_after_write", {16'd0, rcnt[1]}, 32'd1);

    xact(1, 1'b0, 10'd5, 16'h0000, rd, e, k);
    chk("read5_rdata", {16'd0, rd}, 32'h0007);
    chk("read5_err",   {31'd0, e}, 32'd0);
    chk("count_two",   {16'd0, rcnt[1]}, 32'd2);

    // Backpressure; request inputs change and req_valid stays high after accept
    rrd[1] = 1'b0;
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 10'd5; wd[1] = 16'h0000;
    step();
    ra[1] = 10'd7; rw[1] = 1'b1; wd[1] = 16'hDEAD;
    wait_resp(1, k);
    for (int c = 0; c < 6; c++) begin
      chk("bp_valid_held", {31'd0, vld[1]}, 32'd1);
      chk("bp_rdata_held", {16'd0, rdat[1]}, 32'h0007);
      chk("bp_ready_low",  {31'd0, rdy[1]}, 32'd0);
      step();
    end
    rv[1] = 1'b0;
    rrd[1] = 1'b1;
    step();
    chk("bp_hs_valid_low", {31'd0, vld[1]}, 32'd0);
    chk("bp_hs_ready",     {31'd0, rdy[1]}, 32'd1);
    chk("bp_count",        {16'd0, rcnt[1]}, 32'd3);
    step();
    chk("bp_no_second_accept", {31'd0, vld[1]}, 32'd0);

    // Address range boundary, DEPTH 1000
    xact(1, 1'b1, 10'd999, 16'hBEEF, rd, e, k);
    chk("w999_err", {31'd0, e}, 32'd0);
    xact(1, 1'b1, 10'd1000, 16'h1234, rd, e, k);
    chk("w1000_err",   {31'd0, e}, 32'd1);
    chk("w1000_rdata", {16'd0, rd}, 32'd0);
    xact(1, 1'b0, 10'd999, 16'h0000, rd, e, k);
    chk("r999_rdata", {16'd0, rd}, 32'hBEEF);
    chk("r999_err",   {31'd0, e}, 32'd0);
    xact(1, 1'b0, 10'd1000, 16'h0000, rd, e, k);
    chk("r1000_rdata", {16'd0, rd}, 32'd0);
    chk("r1000_err",   {31'd0, e}, 32'd1);
    xact(1, 1'b0, 10'd5, 16'h0000, rd, e, k);
    chk("r5_after_oor", {16'd0, rd}, 32'h0007);

    // Reset during WAIT drops a pending write
    xact(1, 1'b1, 10'd3, 16'h0011, rd, e, k);
    send(1, 1'b1, 10'd3, 16'h00AA);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, vld[1]}, 32'd0);
    chk("midrst_count", {16'd0, rcnt[1]}, 32'd0);
    chk("midrst_ready", {31'd0, rdy[1]}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    xact(1, 1'b0, 10'd3, 16'h0000, rd, e, k);
    chk("r3_not_committed", {16'd0, rd}, 32'h0011);
    xact(1, 1'b0, 10'd5, 16'h0000, rd, e, k);
    chk("r5_persist", {16'd0, rd}, 32'h0007);
    chk("count_after_rst", {16'd0, rcnt[1]}, 32'd2);

    // Latency sweep
    xact(0, 1'b1, 10'd4, 16'h0055, rd, e, k);
    chk("lat0_delay", k, 32'd1);
    xact(0, 1'b0, 10'd4, 16'h0000, rd, e, k);
    chk("lat0_rdata", {16'd0, rd}, 32'h0055);
    xact(2, 1'b1, 10'd1023, 16'hA5A5, rd, e, k);
    chk("lat15_delay", k, 32'd16);
    chk("lat15_err_top_addr", {31'd0, e}, 32'd0);
    xact(2, 1'b0, 10'd1023, 16'h0000, rd, e, k);
    chk("lat15_rdata", {16'd0, rd}, 32'hA5A5);

    // resp_count wrap
    force u_l0.resp_count = 16'hFFFE;
    #1;
    release u_l0.resp_count;
    xact(0, 1'b0, 10'd4, 16'h0000, rd, e, k);
    chk("count_ffff", {16'd0, rcnt[0]}, 32'h0000FFFF);
    xact(0, 1'b0, 10'd4, 16'h0000, rd, e, k);
    chk("count_wrap", {16'd0, rcnt[0]}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
